// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - div_unit state encodings, iteration count and operand magnitude helper
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  localparam int DIV_ITER = 32;

  // Two's-complement magnitude when signed; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (optional DIV_EARLY_OUT_EN)
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divider_i,
  input  logic        start_i,
  input  logic        cancel_i,
  output logic [63:0] result_o,
  output logic        success_o
);

  div_state_e  state, state_next;
  logic [5:0]  cnt;
  logic [31:0] dvd, dsr, rem, quo;
  logic        dvd_neg, dsr_neg, sgn;
  logic [32:0] trial;
  logic [31:0] rem_step, quo_step, rem_fix, quo_fix;
  logic [31:0] dvd_mag, dsr_mag;
  logic        early_out;
  logic        last_iter;

  always_comb begin
    dvd_mag = mag32(dividend_i, signed_i);
    dsr_mag = mag32(divider_i, signed_i);
`ifdef DIV_EARLY_OUT_EN
    early_out = (dvd_mag < dsr_mag);
`else
    early_out = 1'b0;
`endif
    trial = {rem, dvd[31]} - {1'b0, dsr};
    if (!trial[32]) begin
      rem_step = trial[31:0];
      quo_step = {quo[30:0], 1'b1};
    end else begin
      rem_step = {rem[30:0], dvd[31]};
      quo_step = {quo[30:0], 1'b0};
    end
    quo_fix   = (sgn && (dvd_neg ^ dsr_neg)) ? (~quo_step + 32'd1) : quo_step;
    rem_fix   = (sgn && dvd_neg) ? (~rem_step + 32'd1) : rem_step;
    last_iter = (cnt == 6'(DIV_ITER - 1));
  end

  always_comb begin
    state_next = state;
    success_o  = (state == DIV_END);
    case (state)
      DIV_IDLE: begin
        if (start_i) begin
          if (divider_i == 32'd0) state_next = DIV_BYZERO;
          else if (early_out)     state_next = DIV_END;
          else                    state_next = DIV_ON;
        end
      end
      DIV_BYZERO: state_next = DIV_END;
      DIV_ON:     if (last_iter) state_next = DIV_END;
      DIV_END:    if (!start_i) state_next = DIV_IDLE;
      default:    state_next = DIV_IDLE;
    endcase
    if (cancel_i) state_next = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_IDLE;
      result_o <= 64'd0;
      cnt      <= 6'd0;
      dvd      <= 32'd0;
      dsr      <= 32'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvd_neg  <= 1'b0;
      dsr_neg  <= 1'b0;
      sgn      <= 1'b0;
    end else begin
      state <= state_next;
      if (cancel_i) begin
        result_o <= 64'd0;
      end else begin
        case (state)
          DIV_IDLE: begin
            if (start_i && divider_i != 32'd0) begin
              if (early_out) begin
                // Remainder keeps the dividend exactly as presented, sign included.
                result_o <= {dividend_i, 32'd0};
              end else begin
                dvd     <= dvd_mag;
                dsr     <= dsr_mag;
                rem     <= 32'd0;
                quo     <= 32'd0;
                cnt     <= 6'd0;
                dvd_neg <= dividend_i[31];
                dsr_neg <= divider_i[31];
                sgn     <= signed_i;
              end
            end
          end
          DIV_BYZERO: result_o <= 64'd0;
          DIV_ON: begin
            rem <= rem_step;
            quo <= quo_step;
            dvd <= {dvd[30:0], 1'b0};
            cnt <= cnt + 6'd1;
            if (last_iter) result_o <= {rem_fix, quo_fix};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - table-driven self-checking bench for div_unit
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, signed_i, start_i, cancel_i;
  logic [31:0] dividend_i, divider_i;
  logic [63:0] result_o;
  logic        success_o;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .signed_i(signed_i), .dividend_i(dividend_i),
    .divider_i(divider_i), .start_i(start_i), .cancel_i(cancel_i),
    .result_o(result_o), .success_o(success_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        early;
  } vec_t;

  vec_t vt[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts in an IDLE cycle (cycle 0), waits for success, then drops start for one IDLE cycle.
  task automatic run_div(input string nm, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] res, input int lat);
    int n;
    logic [63:0] held;
    signed_i   = sgn;
    dividend_i = a;
    divider_i  = b;
    start_i    = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        dividend_i = $urandom;
        divider_i  = $urandom;
      end
    end while (!success_o && n < 60);
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    chk({nm, "_res"}, result_o, res);
    held    = result_o;
    start_i = 1'b0;
    step();
    chk({nm, "_idle_succ"}, 64'(success_o), 64'd0);
    chk({nm, "_idle_hold"}, result_o, held);
  endtask

  initial begin
    int n, nsucc, lat;
    vt[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         1'b0};
    vt[1]  = '{1'b1, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF,   32'hFFFFFFFD},   1'b0};
    vt[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0,          32'h80000000},   1'b0};
    vt[3]  = '{1'b0, 32'd5,          32'd0,          64'd0,                            1'b0};
    vt[4]  = '{1'b0, 32'd5,          32'd7,          {32'd5,          32'd0},          1'b1};
    vt[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD},   1'b0};
    vt[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF,   32'd3},          1'b0};
    vt[7]  = '{1'b0, 32'hFFFFFFFF,   32'd2,          {32'd1,          32'h7FFFFFFF},   1'b0};
    vt[8]  = '{1'b1, 32'hFFFFFFFF,   32'd5,          {32'hFFFFFFFF,   32'd0},          1'b1};
    vt[9]  = '{1'b0, 32'hFFFFFFFF,   32'd5,          {32'd0,          32'h33333333},   1'b0};
    vt[10] = '{1'b0, 32'h000F4240,   32'h3E8,        {32'd0,          32'h3E8},        1'b0};
    vt[11] = '{1'b1, 32'h80000000,   32'd2,          {32'd0,          32'hC0000000},   1'b0};
    vt[12] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000,   32'd0},          1'b1};

    rst = 1'b1; signed_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
    dividend_i = 32'd0; divider_i = 32'd0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_res", result_o, 64'd0);
    chk("reset_succ", 64'(success_o), 64'd0);

    foreach (vt[i]) begin
      if (vt[i].b == 32'd0)          lat = 2;
      else if (EARLY && vt[i].early) lat = 1;
      else                           lat = 33;
      run_div($sformatf("vec%0d", i), vt[i].sgn, vt[i].a, vt[i].b, vt[i].res, lat);
    end

    // Cancel in cycle 10, restart in cycle 12, done in cycle 45.
    signed_i = 1'b0; dividend_i = 32'hFFFFFFFF; divider_i = 32'd1; start_i = 1'b1;
    repeat (10) step();
    cancel_i = 1'b1;
    step();
    cancel_i = 1'b0; start_i = 1'b0;
    chk("cancel_res", result_o, 64'd0);
    chk("cancel_succ", 64'(success_o), 64'd0);
    step();
    run_div("after_cancel", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33);

    // start held through END: success and result stay put.
    signed_i = 1'b0; dividend_i = 32'd100; divider_i = 32'd7; start_i = 1'b1;
    n = 0;
    do begin step(); n++; end while (!success_o && n < 60);
    chk("hold_lat", 64'(n), 64'd33);
    repeat (3) step();
    chk("hold_succ", 64'(success_o), 64'd1);
    chk("hold_res", result_o, {32'd2, 32'd14});
    start_i = 1'b0;
    step();
    chk("hold_release", 64'(success_o), 64'd0);

    // Reset mid-operation with start and cancel both high.
    dividend_i = 32'd1000; divider_i = 32'd3; start_i = 1'b1;
    repeat (5) step();
    rst = 1'b1; cancel_i = 1'b1;
    step();
    rst = 1'b0; cancel_i = 1'b0; start_i = 1'b0;
    chk("midrst_res", result_o, 64'd0);
    nsucc = 0;
    repeat (40) begin step(); if (success_o) nsucc++; end
    chk("midrst_nosucc", 64'(nsucc), 64'd0);

    // start coinciding with cancel in IDLE is ignored (a /0 request would succeed in cycle 2).
    dividend_i = 32'd5; divider_i = 32'd0; start_i = 1'b1; cancel_i = 1'b1;
    step();
    start_i = 1'b0; cancel_i = 1'b0;
    step();
    chk("startcancel_succ", 64'(success_o), 64'd0);
    step();
    chk("startcancel_succ2", 64'(success_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
